// File: rtl/temporal_encoder.sv
// temporal_encoder: turns a spike-time value into one fixed-width pulse per gamma cycle,
// with a one-deep holding slot, gamma-clear/start strobes and a sticky underrun flag.
module temporal_encoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH = 8,
   parameter int VAL_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic             aclk,
   input  logic             grst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VAL_W-1:0] in_value,
   input  logic             in_null,
   output logic             q,
   output logic             gclr,
   output logic             gamma_start,
   output logic             underrun
);
   localparam int CW = $clog2(GAMMA_CYCLE_WIDTH);
   localparam int AW = (VAL_W > CW ? VAL_W : CW) + 1;
   localparam logic [AW-1:0] LAST = AW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [AW-1:0] MAXV = AW'(GAMMA_CYCLE_WIDTH - 1 - PULSE_WIDTH);
   localparam logic [AW-1:0] PWM1 = AW'(PULSE_WIDTH - 1);

   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic [VAL_W-1:0] r_next_v;
   logic             r_next_null;
   logic             r_next_full;
   logic [VAL_W-1:0] r_act_v;
   logic             r_act_null;
   logic             r_q;
   logic             r_gclr;
   logic             r_gamma_start;
   logic             r_underrun;

   logic             w_bnd;
   logic             w_acc;
   logic [CW-1:0]    w_cnt_n;
   logic [VAL_W-1:0] w_act_v_n;
   logic             w_act_null_n;
   logic [AW-1:0]    w_cnt_x;
   logic [AW-1:0]    w_v_x;
   logic [AW-1:0]    w_in_x;
   logic             w_q_n;

   // The first edge after reset is treated as a boundary so gamma 0 starts at cnt=0.
   assign w_bnd        = !r_run || ({{(AW-CW){1'b0}}, r_cnt} == LAST);
   assign w_acc        = in_valid && !r_next_full;
   assign w_cnt_n      = w_bnd ? '0 : r_cnt + CW'(1);
   assign w_act_v_n    = (w_bnd && r_next_full) ? r_next_v : r_act_v;
   assign w_act_null_n = w_bnd ? (!r_next_full || r_next_null) : r_act_null;
   assign w_cnt_x      = {{(AW-CW){1'b0}}, w_cnt_n};
   assign w_v_x        = {{(AW-VAL_W){1'b0}}, w_act_v_n};
   assign w_in_x       = {{(AW-VAL_W){1'b0}}, in_value};
   assign w_q_n        = !w_act_null_n && (w_cnt_x >= w_v_x) && (w_cnt_x <= w_v_x + PWM1);

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_cnt         <= '0;
         r_run         <= 1'b0;
         r_next_v      <= '0;
         r_next_null   <= 1'b1;
         r_next_full   <= 1'b0;
         r_act_v       <= '0;
         r_act_null    <= 1'b1;
         r_q           <= 1'b0;
         r_gclr        <= 1'b0;
         r_gamma_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_n;
         r_run         <= 1'b1;
         r_act_v       <= w_act_v_n;
         r_act_null    <= w_act_null_n;
         r_q           <= w_q_n;
         r_gclr        <= w_cnt_x == LAST;
         r_gamma_start <= w_cnt_n == '0;
         if (w_bnd && !r_next_full)
            r_underrun <= 1'b1;
         // Out-of-range values are folded into null at accept so they never pulse.
         if (w_acc) begin
            r_next_v    <= in_value;
            r_next_null <= in_null || (w_in_x > MAXV);
            r_next_full <= 1'b1;
         end else if (w_bnd) begin
            r_next_full <= 1'b0;
         end
      end
   end

   assign in_ready    = !r_next_full;
   assign q           = r_q;
   assign gclr        = r_gclr;
   assign gamma_start = r_gamma_start;
   assign underrun    = r_underrun;
endmodule

// File: tb/tb_temporal_encoder.sv
// tb_temporal_encoder: scoreboard bench; accepted values queue up and are popped into a
// gamma-level reference model at each boundary, which predicts every output each cycle.
module tb_temporal_encoder;
   localparam int G  = 16;
   localparam int PW = 8;

   typedef struct {
      int v;
      bit n;
   } item_t;

   logic       aclk = 1'b0;
   logic       grst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_value;
   logic       in_null;
   logic       q;
   logic       gclr;
   logic       gamma_start;
   logic       underrun;

   int    checks = 0;
   int    errors = 0;
   item_t sb[$];
   bit    mon_en = 1'b0;
   int    mc = -1;
   int    act_v = 0;
   bit    act_null = 1'b1;
   bit    und = 1'b0;

   temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
      .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_null(in_null), .q(q), .gclr(gclr),
      .gamma_start(gamma_start), .underrun(underrun)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t (model cnt %0d)", tag, got, exp, $time, mc);
      end
   endtask

   task automatic pop_active();
      item_t it;
      mc = 0;
      if (sb.size() != 0) begin
         it = sb.pop_front();
         act_v = it.v;
         act_null = it.n || (it.v > G - 1 - PW);
      end else begin
         act_null = 1'b1;
         und = 1'b1;
      end
   endtask

   initial forever begin
      @(negedge aclk);
      if (mon_en) begin
         if (mc < 0) begin
            check("rel_q", q, 0);
            check("rel_gamma_start", gamma_start, 0);
            check("rel_underrun", underrun, 0);
            check("rel_in_ready", in_ready, 1);
            pop_active();
         end else begin
            check("q", q, (!act_null && mc >= act_v && mc <= act_v + PW - 1) ? 1 : 0);
            check("gclr", gclr, (mc == G - 1) ? 1 : 0);
            check("gamma_start", gamma_start, (mc == 0) ? 1 : 0);
            check("underrun", underrun, und);
            check("in_ready", in_ready, (sb.size() == 0) ? 1 : 0);
            if (mc == G - 1) pop_active();
            else mc++;
         end
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      grst = 1'b1;
      #1;
      check("rst_q", q, 0);
      check("rst_gclr", gclr, 0);
      check("rst_gamma_start", gamma_start, 0);
      check("rst_underrun", underrun, 0);
      check("rst_in_ready", in_ready, 1);
      sb.delete();
      und = 1'b0;
      act_null = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      grst = 1'b0;
      mc = -1;
      mon_en = 1'b1;
   endtask

   task automatic goto_cnt(input int c);
      for (int i = 0; i < 64; i++) begin
         @(posedge aclk);
         #1;
         if (mc == c) break;
      end
      check("goto_cnt", mc, c);
   endtask

   task automatic send(input int v, input bit n);
      in_value = 4'(v);
      in_null = n;
      in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge aclk);
         if (in_ready) break;
      end
      check("ready_wait", in_ready, 1);
      @(posedge aclk);
      #1;
      sb.push_back('{v: v, n: n});
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   initial begin
      grst = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      in_null = 1'b0;
      #1;
      do_reset();
      goto_cnt(2);
      send(3, 1'b0);
      send(0, 1'b0);
      send(7, 1'b0);
      send(8, 1'b0);
      idle(3 * G);
      send(0, 1'b1);
      idle(2 * G + 8);
      goto_cnt(G - 1);
      send(5, 1'b0);
      idle(2 * G + 8);
      for (int i = 0; i < 6; i++) begin
         idle($urandom_range(0, 20));
         send($urandom_range(0, 12), $urandom_range(0, 3) == 0);
      end
      idle(3 * G);
      goto_cnt(1);
      send(3, 1'b0);
      goto_cnt(G - 1);
      goto_cnt(5);
      #1;
      check("q_before_rst", q, 1);
      do_reset();
      idle(2 * G + 4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
